// File: rtl/mult32_seq_if.sv
// mult32_seq_if
// Handshake and data bundle between a multiplier requester and mult32_seq.
//   start : request, sampled by the multiplier only while idle
//   A, B  : 32-bit unsigned multiplicand / multiplier, captured on accept
//   busy  : high while the multiplier is iterating
//   done  : one-cycle pulse marking a valid product
//   P     : 64-bit product {acc_hi, acc_lo}
// master = requester side, slave = multiplier side.
interface mult32_seq_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] P;

  modport master (output start, A, B, input busy, done, P);
  modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/mult32_seq.sv
// mult32_seq
// Sequential 32x32 unsigned shift-and-add multiplier. One 32-bit ripple-carry
// adder is reused for all 32 partial products; each RUN cycle adds the
// multiplicand (gated by the current multiplier LSB) into the upper
// accumulator and shifts the {carry, sum, acc_lo} word right by one.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mult32_seq_if.slave (start, A, B in; busy, done, P out)
// Timing: accept at edge E0, busy for 32 cycles, done for one cycle, then
// IDLE again; a held start is re-accepted one cycle after that.
module mult32_seq (
  input  logic         clk,
  input  logic         reset_n,
  mult32_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    SPARE = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] mcand_reg;
  logic [31:0] acc_hi_reg;
  logic [31:0] acc_lo_reg;
  logic [4:0]  cnt_reg;

  logic        load;
  logic        step;
  logic        busy;
  logic        done;

  // Shared adder: A = acc_hi, B = gated multiplicand, carry-in tied to 0.
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum;
  logic [32:0] carry;
  logic        pout;

  assign add_a    = acc_hi_reg;
  assign add_b    = acc_lo_reg[0] ? mcand_reg : 32'h0;
  assign carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rca
      assign sum[gi]      = add_a[gi] ^ add_b[gi] ^ carry[gi];
      assign carry[gi+1]  = (add_a[gi] & add_b[gi]) |
                            (carry[gi] & (add_a[gi] ^ add_b[gi]));
    end
  endgenerate

  assign pout = carry[32];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = IDLE;
    load       = 1'b0;
    step       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        busy       = 1'b1;
        step       = 1'b1;
        state_next = (cnt_reg == 5'd31) ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        // Unused encoding: behave as idle outputs but never accept; recover.
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= 32'h0;
      acc_hi_reg <= 32'h0;
      acc_lo_reg <= 32'h0;
      cnt_reg    <= 5'd0;
    end else if (load) begin
      mcand_reg  <= bus.A;
      acc_hi_reg <= 32'h0;
      acc_lo_reg <= bus.B;
      cnt_reg    <= 5'd0;
    end else if (step) begin
      // Right shift of the 65-bit {Pout, S, acc_lo}; the consumed multiplier
      // bit falls off the bottom while a product bit enters acc_lo[31].
      acc_hi_reg <= {pout, sum[31:1]};
      acc_lo_reg <= {sum[0], acc_lo_reg[31:1]};
      cnt_reg    <= cnt_reg + 5'd1;
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.P    = {acc_hi_reg, acc_lo_reg};

endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq
// Directed testbench for mult32_seq: hand-computed products, busy/done
// timing, ignored start in RUN/DONE, asynchronous reset mid-operation and
// back-to-back operation with start held high.
module tb_mult32_seq;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  mult32_seq_if bus ();

  mult32_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Called at a negedge in IDLE. Accepts one operation, checks the busy
  // window length, the done pulse and the product, and that P holds after.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    int busy_cnt;
    busy_cnt = 0;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, " done"}, {63'h0, bus.done}, 64'd1);
    check({tag, " busy_at_done"}, {63'h0, bus.busy}, 64'd0);
    check({tag, " P"}, bus.P, exp);
    @(negedge clk);
    check({tag, " done_gone"}, {63'h0, bus.done}, 64'd0);
    check({tag, " P_hold"}, bus.P, exp);
    $display("op %s: A=%h B=%h P=%h", tag, a, b, bus.P);
  endtask

  initial begin
    int dones;
    int last_done;
    int periods_ok;
    logic [63:0] p_at_done;

    n_cmp     = 0;
    n_bad     = 0;
    bus.start = 1'b0;
    bus.A     = 32'h0;
    bus.B     = 32'h0;
    reset_n   = 1'b0;

    repeat (2) @(negedge clk);
    check("reset P", bus.P, 64'h0);
    check("reset busy", {63'h0, bus.busy}, 64'd0);
    check("reset done", {63'h0, bus.done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic, max and zero-operand products
    do_op("3x5", 32'd3, 32'd5, 64'd15);
    repeat (3) @(negedge clk);
    check("3x5 idle_hold", bus.P, 64'd15);
    do_op("maxmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    do_op("zeroA", 32'h0, 32'h12345678, 64'h0);
    do_op("zeroB", 32'h12345678, 32'h0, 64'h0);

    // Ignored start: pulses in RUN (k=5) and DONE (k=32) must not matter.
    bus.A     = 32'd7;
    bus.B     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones     = 0;
    p_at_done = 64'h0;
    for (int k = 0; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        dones++;
        p_at_done = bus.P;
      end
      bus.start = (k == 5 || k == 32);
      bus.A     = (k == 5 || k == 32) ? 32'd1 : 32'd7;
      bus.B     = (k == 5 || k == 32) ? 32'd1 : 32'd9;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("ign done_count", 64'(dones), 64'd1);
    check("ign P_at_done", p_at_done, 64'd63);
    check("ign busy_after", {63'h0, bus.busy}, 64'd0);
    check("ign P_after", bus.P, 64'd63);
    $display("op ignored_start: dones=%0d P=%h", dones, bus.P);

    // Asynchronous reset in the middle of an operation
    bus.A     = 32'h10000;
    bus.B     = 32'h10000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("rst busy_before", {63'h0, bus.busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst P", bus.P, 64'h0);
    check("rst busy", {63'h0, bus.busy}, 64'd0);
    check("rst done", {63'h0, bus.done}, 64'd0);
    $display("op reset_mid: P=%h busy=%b done=%b", bus.P, bus.busy, bus.done);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_op("after_rst", 32'd2, 32'h80000000, 64'h1_00000000);

    // start held high: an operation every 34 cycles (32 RUN + DONE + IDLE)
    bus.A      = 32'h0000FFFF;
    bus.B      = 32'h0000FFFF;
    bus.start  = 1'b1;
    dones      = 0;
    last_done  = -1;
    periods_ok = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        check("cont P", bus.P, 64'h00000000_FFFE0001);
        if (last_done >= 0) begin
          check("cont period", 64'(k - last_done), 64'd34);
          periods_ok++;
        end
        $display("op continuous: pulse=%0d cycle=%0d P=%h", dones, k, bus.P);
        last_done = k;
      end
    end
    bus.start = 1'b0;
    check("cont pulses", 64'(dones >= 3), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
